// File: rtl/seq_shift_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_shift_unit                                                   |
// | Brief   : Multi-cycle rotate/shift unit moving up to STEP bits per cycle.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module seq_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] Rin,
    input  logic [SW-1:0]    n,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Rx,
    output logic             carry
);

    localparam logic [2:0] c_op_ror = 3'd0;
    localparam logic [2:0] c_op_rol = 3'd1;
    localparam logic [2:0] c_op_lsr = 3'd2;
    localparam logic [2:0] c_op_lsl = 3'd3;
    localparam logic [2:0] c_op_asr = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_val;
    logic [SW-1:0]    r_rem;

    logic [SW-1:0]    w_k;
    logic [SW-1:0]    w_kc;
    logic [SW-1:0]    w_km1;
    logic [WIDTH-1:0] w_rsh;
    logic [WIDTH-1:0] w_lsh;
    logic [WIDTH-1:0] w_res;
    logic             w_cout;

    // k = min(STEP, remaining); WIDTH-k wraps to the right value modulo 2**SW.
    always_comb begin
        w_k = r_rem;
        if (int'(r_rem) > STEP)
            w_k = SW'(STEP);
        w_kc  = SW'(0) - w_k;
        w_km1 = w_k - SW'(1);
        w_rsh = r_val >> w_km1;
        w_lsh = r_val << w_km1;
        w_res  = r_val;
        w_cout = 1'b0;
        case (r_op)
            c_op_ror: begin
                w_res  = (r_val >> w_k) | (r_val << w_kc);
                w_cout = w_rsh[0];
            end
            c_op_rol: begin
                w_res  = (r_val << w_k) | (r_val >> w_kc);
                w_cout = w_lsh[WIDTH-1];
            end
            c_op_lsr: begin
                w_res  = r_val >> w_k;
                w_cout = w_rsh[0];
            end
            c_op_lsl: begin
                w_res  = r_val << w_k;
                w_cout = w_lsh[WIDTH-1];
            end
            c_op_asr: begin
                w_res  = $signed(r_val) >>> w_k;
                w_cout = w_rsh[0];
            end
            default: begin
                w_res  = r_val;
                w_cout = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_val   <= '0;
            r_rem   <= '0;
            Rx      <= '0;
            carry   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_op  <= op;
                        r_val <= Rin;
                        r_rem <= n;
                        if (n != '0 && op <= c_op_asr) begin
                            r_state <= S_SHIFT;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            Rx      <= Rin;
                            carry   <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_val <= w_res;
                    r_rem <= r_rem - w_k;
                    if (r_rem == w_k) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        Rx      <= w_res;
                        carry   <= w_cout;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_seq_shift_unit                                                |
// | Brief   : Scoreboard bench driving a STEP=1 and a STEP=4 instance.         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_seq_shift_unit;

    typedef struct {
        logic [31:0] rx;
        logic        c;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        en1;
    logic        en4;
    logic [2:0]  op;
    logic [31:0] rin;
    logic [4:0]  n;
    logic        start1;
    logic        start4;
    logic        busy1, done1, carry1;
    logic        busy4, done4, carry4;
    logic [31:0] rx1, rx4;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q1[$];
    exp_t q4[$];

    assign start1 = start & en1;
    assign start4 = start & en4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_shift_unit #(.WIDTH(32), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op), .Rin(rin), .n(n),
        .busy(busy1), .done(done1), .Rx(rx1), .carry(carry1)
    );

    seq_shift_unit #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op), .Rin(rin), .n(n),
        .busy(busy4), .done(done4), .Rx(rx4), .carry(carry4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat(input logic [2:0] o, input logic [4:0] nn, input int step);
        if (nn == 5'd0 || o > 3'd4)
            return 1;
        return (int'(nn) + step - 1) / step + 1;
    endfunction

    // Called just after a negedge; returns one negedge later with start released.
    task automatic start_op(input logic [2:0] o, input logic [31:0] r, input logic [4:0] nn,
                            input bit e1, input bit e4, input bit push,
                            input logic [31:0] exp_rx, input logic exp_c);
        exp_t e;
        op    = o;
        rin   = r;
        n     = nn;
        en1   = e1;
        en4   = e4;
        start = 1'b1;
        if (push) begin
            e.rx = exp_rx;
            e.c  = exp_c;
            if (e1) begin
                e.cyc = cyc + lat(o, nn, 1);
                q1.push_back(e);
            end
            if (e4) begin
                e.cyc = cyc + lat(o, nn, 4);
                q4.push_back(e);
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] r, input logic [4:0] nn,
                       input logic [31:0] exp_rx, input logic exp_c);
        start_op(o, r, nn, 1'b1, 1'b1, 1'b1, exp_rx, exp_c);
        if (lat(o, nn, 1) == 1) begin
            check("dut1 busy on immediate op", {31'd0, busy1}, 32'd0);
            check("dut4 busy on immediate op", {31'd0, busy4}, 32'd0);
        end
        repeat (40) @(negedge clk);
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut1 unexpected done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                e = q1.pop_front();
                check("dut1 Rx", rx1, e.rx);
                check("dut1 carry", {31'd0, carry1}, {31'd0, e.c});
                check("dut1 done cycle", cyc, e.cyc);
                check("dut1 busy in done", {31'd0, busy1}, 32'd0);
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (done4) begin
            if (q4.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL dut4 unexpected done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                e = q4.pop_front();
                check("dut4 Rx", rx4, e.rx);
                check("dut4 carry", {31'd0, carry4}, {31'd0, e.c});
                check("dut4 done cycle", cyc, e.cyc);
                check("dut4 busy in done", {31'd0, busy4}, 32'd0);
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        en1   = 1'b0;
        en4   = 1'b0;
        op    = 3'd0;
        rin   = 32'd0;
        n     = 5'd0;
        repeat (3) @(negedge clk);
        check("reset dut1 Rx", rx1, 32'd0);
        check("reset dut1 flags", {29'd0, busy1, done1, carry1}, 32'd0);
        check("reset dut4 Rx", rx4, 32'd0);
        check("reset dut4 flags", {29'd0, busy4, done4, carry4}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run(3'd0, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b1);
        run(3'd1, 32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0);
        run(3'd4, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0);
        run(3'd2, 32'hF000_0000, 5'd31, 32'h0000_0001, 1'b1);
        run(3'd3, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b1);
        run(3'd1, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0);
        run(3'd7, 32'hDEAD_BEEF, 5'd9,  32'hDEAD_BEEF, 1'b0);
        // ROR by 5 of 0x1F: the last bit rotated out is original bit 4.
        run(3'd0, 32'h0000_001F, 5'd5,  32'hF800_0000, 1'b1);

        // STEP=4 only: start during SHIFT is ignored, start during DONE chains.
        start_op(3'd0, 32'h0000_001F, 5'd5, 1'b0, 1'b1, 1'b1, 32'hF800_0000, 1'b1);
        check("dut4 busy cycle 1", {31'd0, busy4}, 32'd1);
        start_op(3'd2, 32'hFFFF_FFFF, 5'd1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        check("dut4 busy cycle 2", {31'd0, busy4}, 32'd1);
        @(negedge clk);
        check("dut4 done cycle 3", {31'd0, done4}, 32'd1);
        start_op(3'd4, 32'h8000_0018, 5'd4, 1'b0, 1'b1, 1'b1, 32'hF800_0001, 1'b1);
        repeat (10) @(negedge clk);

        // Abort an n=10 LSL on dut1 with reset during its third SHIFT cycle.
        start_op(3'd3, 32'h00C0_FFFF, 5'd10, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        check("dut1 busy before abort", {31'd0, busy1}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort dut1 Rx", rx1, 32'd0);
        check("abort dut1 flags", {29'd0, busy1, done1, carry1}, 32'd0);
        check("abort dut4 Rx", rx4, 32'd0);
        repeat (20) @(negedge clk);

        run(3'd3, 32'h00C0_FFFF, 5'd10, 32'h03FF_FC00, 1'b1);

        for (int i = 0; i < 100 && (q1.size() != 0 || q4.size() != 0); i++)
            @(negedge clk);
        while (q1.size() != 0) begin
            void'(q1.pop_front());
            n_checks++;
            n_fail++;
            $display("FAIL dut1 missing done: got none expected a done pulse");
        end
        while (q4.size() != 0) begin
            void'(q4.pop_front());
            n_checks++;
            n_fail++;
            $display("FAIL dut4 missing done: got none expected a done pulse");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
